// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: datapath widths, control-bundle bit indices,
// forwarding-source encoding and the register-dependency helper.
package cpu_pkg;

   localparam int XLEN           = 32;
   localparam int CTRL_W         = 16;
   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_READ  = 1;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2
   } fwd_sel_t;

   // True when a writer targets rs; x0 is hard-wired and never counts as a producer
   function automatic logic reg_match(input logic       wr,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Single-operand forwarding select and mux for the EX stage: the younger
// EX/MEM result beats MEM/WB, which beats the captured register-file data.
module fwd_unit #(
   parameter int XLEN = cpu_pkg::XLEN
) (
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic            exm_reg_write,
   input  logic [4:0]      exm_rd,
   input  logic [XLEN-1:0] exm_data,
   input  logic            mwb_reg_write,
   input  logic [4:0]      mwb_rd,
   input  logic [XLEN-1:0] mwb_data,
   output logic [XLEN-1:0] data
);
   import cpu_pkg::*;

   fwd_sel_t sel_s;

   // Source select
   always_comb begin
      sel_s = FWD_RF;
      if (reg_match(exm_reg_write, exm_rd, rs)) begin
         sel_s = FWD_EXM;
      end else if (reg_match(mwb_reg_write, mwb_rd, rs)) begin
         sel_s = FWD_MWB;
      end else begin
         sel_s = FWD_RF;
      end
   end

   // Operand mux
   always_comb begin
      data = rf_data;
      case (sel_s)
         FWD_EXM: data = exm_data;
         FWD_MWB: data = mwb_data;
         FWD_RF:  data = rf_data;
         default: data = rf_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, operand refresh under stall
// and load-use bubbles; FORWARD_EN selects forwarding, otherwise RAW stalls.
module id_ex_stage #(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int CTRL_W = cpu_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [XLEN-1:0]   id_rd_data1,
   input  logic [XLEN-1:0]   id_rd_data2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              exm_reg_write,
   input  logic [4:0]        exm_rd,
   input  logic [XLEN-1:0]   exm_data,
   input  logic              mwb_reg_write,
   input  logic [4:0]        mwb_rd,
   input  logic [XLEN-1:0]   mwb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic              hazard_stall
);
   import cpu_pkg::*;

   logic              ex_valid_r;
   logic [XLEN-1:0]   ex_pc_r;
   logic [XLEN-1:0]   ex_imm_r;
   logic [4:0]        ex_rs1_r;
   logic [4:0]        ex_rs2_r;
   logic [4:0]        ex_rd_r;
   logic [CTRL_W-1:0] ex_ctrl_r;
   logic [XLEN-1:0]   rd_data1_r;
   logic [XLEN-1:0]   rd_data2_r;
   logic [XLEN-1:0]   op1_s;
   logic [XLEN-1:0]   op2_s;
   logic              ex_dep_wr_s;
   logic              exm_dep_wr_s;
   logic              hazard_s;
   logic              bubble_s;

`ifdef FORWARD_EN
   fwd_unit #(.XLEN(XLEN)) u_fwd_op1 (
      .rs            (ex_rs1_r),
      .rf_data       (rd_data1_r),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_data      (exm_data),
      .mwb_reg_write (mwb_reg_write),
      .mwb_rd        (mwb_rd),
      .mwb_data      (mwb_data),
      .data          (op1_s)
   );

   fwd_unit #(.XLEN(XLEN)) u_fwd_op2 (
      .rs            (ex_rs2_r),
      .rf_data       (rd_data2_r),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_data      (exm_data),
      .mwb_reg_write (mwb_reg_write),
      .mwb_rd        (mwb_rd),
      .mwb_data      (mwb_data),
      .data          (op2_s)
   );

   // Only a load in EX is too late to forward
   assign ex_dep_wr_s  = ex_valid_r & ex_ctrl_r[CTRL_MEM_READ];
   assign exm_dep_wr_s = 1'b0;
`else
   logic unused_s;

   assign op1_s        = rd_data1_r;
   assign op2_s        = rd_data2_r;
   // Without bypass every in-flight writer ahead of MEM/WB must drain first
   assign ex_dep_wr_s  = ex_valid_r & ex_ctrl_r[CTRL_REG_WRITE];
   assign exm_dep_wr_s = exm_reg_write;
   assign unused_s     = ^{exm_data, mwb_reg_write, mwb_rd, mwb_data};
`endif

   // Hazard detection against the instruction waiting in ID
   always_comb begin
      hazard_s = id_valid &&
                 (reg_match(ex_dep_wr_s,  ex_rd_r, id_rs1) ||
                  reg_match(ex_dep_wr_s,  ex_rd_r, id_rs2) ||
                  reg_match(exm_dep_wr_s, exm_rd,  id_rs1) ||
                  reg_match(exm_dep_wr_s, exm_rd,  id_rs2));
      bubble_s = flush || (!stall && hazard_s);
   end

   // Pipeline register update: flush > stall > bubble > load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_r <= 1'b0;
         ex_pc_r    <= {XLEN{1'b0}};
         ex_imm_r   <= {XLEN{1'b0}};
         ex_rs1_r   <= 5'd0;
         ex_rs2_r   <= 5'd0;
         ex_rd_r    <= 5'd0;
         ex_ctrl_r  <= {CTRL_W{1'b0}};
         rd_data1_r <= {XLEN{1'b0}};
         rd_data2_r <= {XLEN{1'b0}};
      end else if (bubble_s) begin
         ex_valid_r <= 1'b0;
         ex_pc_r    <= {XLEN{1'b0}};
         ex_imm_r   <= {XLEN{1'b0}};
         ex_rs1_r   <= 5'd0;
         ex_rs2_r   <= 5'd0;
         ex_rd_r    <= 5'd0;
         ex_ctrl_r  <= {CTRL_W{1'b0}};
         rd_data1_r <= {XLEN{1'b0}};
         rd_data2_r <= {XLEN{1'b0}};
      end else if (stall) begin
         // Latch forwarded values so a producer retiring during the hold is kept
         if (ex_valid_r) begin
            rd_data1_r <= op1_s;
            rd_data2_r <= op2_s;
         end
      end else begin
         ex_valid_r <= id_valid;
         ex_pc_r    <= id_pc;
         ex_imm_r   <= id_imm;
         ex_rs1_r   <= id_rs1;
         ex_rs2_r   <= id_rs2;
         ex_rd_r    <= id_rd;
         ex_ctrl_r  <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
         rd_data1_r <= id_rd_data1;
         rd_data2_r <= id_rd_data2;
      end
   end

   assign ex_valid     = ex_valid_r;
   assign ex_pc        = ex_pc_r;
   assign ex_imm       = ex_imm_r;
   assign ex_rs1       = ex_rs1_r;
   assign ex_rs2       = ex_rs2_r;
   assign ex_rd        = ex_rd_r;
   assign ex_ctrl      = ex_ctrl_r;
   assign ex_op1       = op1_s;
   assign ex_op2       = op2_s;
   assign hazard_stall = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow FORWARD_EN the same
// way the design does.
module tb_id_ex_stage;
   import cpu_pkg::*;

   localparam logic [15:0] RW = 16'h0001;
   localparam logic [15:0] MR = 16'h0002;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, id_valid;
   logic [31:0] id_pc, id_rd_data1, id_rd_data2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [15:0] id_ctrl;
   logic        exm_reg_write, mwb_reg_write;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_data, mwb_data;
   logic        ex_valid, hazard_stall;
   logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [15:0] ex_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [15:0] ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   int   errors = 0;
   int   checks = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .hazard_stall(hazard_stall)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   // Monitor: an instruction leaving EX (not held, or killed) is compared to the scoreboard
   always @(negedge clk) begin
      if (rst && ex_valid && (!stall || flush)) begin
         if (sb.size() == 0) begin
            chk("unexpected_ex_valid", {27'd0, ex_rd}, 32'hffffffff);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ex_pc",   ex_pc, e.pc);
            chk("ex_imm",  ex_imm, e.imm);
            chk("ex_rd",   {27'd0, ex_rd}, {27'd0, e.rd});
            chk("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
            chk("ex_op1",  ex_op1, e.op1);
            chk("ex_op2",  ex_op2, e.op2);
         end
      end
   end

   task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [15:0] ctrl, input logic [31:0] e1, input logic [31:0] e2);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rd_data1 = d1; id_rd_data2 = d2; id_imm = ~pc; id_ctrl = ctrl;
      pend.pc = pc; pend.imm = ~pc; pend.rd = rd; pend.ctrl = ctrl; pend.op1 = e1; pend.op2 = e2;
   endtask

   task automatic fwd_set(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] md);
      exm_reg_write = ew; exm_rd = erd; exm_data = ed;
      mwb_reg_write = mw; mwb_rd = mrd; mwb_data = md;
   endtask

   // One cycle: check hazard_stall, record what will be loaded, step past the posedge
   task automatic tick(input logic exp_hz);
      @(negedge clk);
      chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hz});
      if (id_valid && !flush && !stall && !exp_hz) sb.push_back(pend);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      id_set(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #3;
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_ex_ctrl",  {16'd0, ex_ctrl}, 32'd0);
      chk("rst_ex_pc",    ex_pc, 32'd0);
      chk("rst_ex_op1",   ex_op1, 32'd0);
      chk("rst_ex_op2",   ex_op2, 32'd0);
      #4 rst = 1'b1;

`ifdef FORWARD_EN
      id_set(1'b1, 32'h300, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, RW, 32'd0, 32'd0);
      tick(1'b0);
      // x5 forwarded from EX/MEM
      id_set(1'b1, 32'h304, 5'd5, 5'd6, 5'd9, 32'hdead, 32'h66, RW, 32'h11, 32'h66);
      tick(1'b0);
      fwd_set(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
      // x0 is never forwarded even when EX/MEM names it
      id_set(1'b1, 32'h308, 5'd0, 5'd6, 5'd0, 32'd0, 32'h66, RW, 32'd0, 32'h66);
      tick(1'b0);
      fwd_set(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0);
      // EX/MEM beats MEM/WB on x6
      id_set(1'b1, 32'h30c, 5'd5, 5'd6, 5'd0, 32'h5, 32'h66, RW, 32'h5, 32'hAA);
      tick(1'b0);
      fwd_set(1'b1, 5'd6, 32'hAA, 1'b1, 5'd6, 32'hBB);
      id_set(1'b1, 32'h310, 5'd2, 5'd6, 5'd0, 32'h2, 32'h66, RW, 32'h2, 32'hBB);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hBB);
      // lw x7 then add x8 = x7 + x1
      id_set(1'b1, 32'h314, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, RW | MR, 32'h1, 32'h2);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      id_set(1'b1, 32'h318, 5'd7, 5'd1, 5'd8, 32'hbad, 32'h1, RW, 32'h77, 32'h1);
      tick(1'b1);
      chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_bubble_ctrl",  {16'd0, ex_ctrl}, 32'd0);
      fwd_set(1'b1, 5'd7, 32'hdddd, 1'b0, 5'd0, 32'd0);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
      id_set(1'b1, 32'h31c, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, RW, 32'd0, 32'd0);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      id_set(1'b1, 32'h320, 5'd3, 5'd0, 5'd4, 32'd0, 32'd0, RW, 32'h42, 32'd0);
      tick(1'b0);
      // Producer of x3 moves EX/MEM -> MEM/WB -> retired while EX is held
      id_set(1'b0, 32'h324, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0);
      stall = 1'b1;
      fwd_set(1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 32'd0);
      #1 chk("refresh_exm", ex_op1, 32'h42);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h42);
      #1 chk("refresh_mwb", ex_op1, 32'h42);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1 chk("refresh_retired", ex_op1, 32'h42);
      tick(1'b0);
      stall = 1'b0;
      tick(1'b0);
`else
      id_set(1'b1, 32'h100, 5'd1, 5'd2, 5'd8, 32'h10, 32'h20, RW, 32'h10, 32'h20);
      tick(1'b0);
      // add after add on x8: two stall cycles (EX, then EX/MEM)
      id_set(1'b1, 32'h104, 5'd8, 5'd3, 5'd9, 32'h99, 32'h3, RW, 32'h18, 32'h3);
      tick(1'b1);
      fwd_set(1'b1, 5'd8, 32'h18, 1'b0, 5'd0, 32'd0);
      tick(1'b1);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h18);
      id_set(1'b1, 32'h104, 5'd8, 5'd3, 5'd9, 32'h18, 32'h3, RW, 32'h18, 32'h3);
      tick(1'b0);
      // writers to x0 never stall
      fwd_set(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h55);
      id_set(1'b1, 32'h108, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, RW, 32'd0, 32'd0);
      tick(1'b0);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      id_set(1'b1, 32'h10c, 5'd0, 5'd4, 5'd10, 32'd0, 32'h44, RW, 32'd0, 32'h44);
      stall = 1'b1;
      tick(1'b0);
      chk("stall_hold_pc", ex_pc, 32'h108);
      tick(1'b0);
      chk("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
      stall = 1'b0;
      tick(1'b0);
      // dependency through rs2
      id_set(1'b1, 32'h110, 5'd1, 5'd10, 5'd11, 32'h1, 32'h0, 16'h0000, 32'h1, 32'h1234);
      tick(1'b1);
      fwd_set(1'b1, 5'd10, 32'h1234, 1'b0, 5'd0, 32'd0);
      tick(1'b1);
      fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1234);
      id_set(1'b1, 32'h110, 5'd1, 5'd10, 5'd11, 32'h1, 32'h1234, 16'h0000, 32'h1, 32'h1234);
      tick(1'b0);
      // EX instruction that does not write a register: no stall
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      id_set(1'b1, 32'h114, 5'd11, 5'd0, 5'd12, 32'hb, 32'd0, RW, 32'hb, 32'd0);
      tick(1'b0);
      // flush with a pending hazard: hazard still reported, flush wins
      id_set(1'b1, 32'h118, 5'd12, 5'd0, 5'd13, 32'd0, 32'd0, RW, 32'd0, 32'd0);
      stall = 1'b1; flush = 1'b1;
      tick(1'b1);
      stall = 1'b0; flush = 1'b0;
      chk("flush_hz_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_hz_ctrl",  {16'd0, ex_ctrl}, 32'd0);
      // invalid decode slot loads a zero-control bubble
      id_set(1'b0, 32'h11c, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, RW, 32'd0, 32'd0);
      tick(1'b0);
      chk("idle_valid", {31'd0, ex_valid}, 32'd0);
      chk("idle_ctrl",  {16'd0, ex_ctrl}, 32'd0);
      chk("idle_pc",    ex_pc, 32'h11c);
`endif

      // flush and stall in the same cycle
      fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      id_set(1'b1, 32'h400, 5'd1, 5'd2, 5'd3, 32'h4, 32'h5, RW, 32'h4, 32'h5);
      tick(1'b0);
      id_set(1'b1, 32'h404, 5'd1, 5'd2, 5'd14, 32'h4, 32'h5, RW, 32'h4, 32'h5);
      stall = 1'b1; flush = 1'b1;
      tick(1'b0);
      stall = 1'b0; flush = 1'b0;
      chk("flush_stall_valid", {31'd0, ex_valid}, 32'd0);

      // asynchronous reset mid-stream, then first posedge after release loads
      id_set(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 32'ha, 32'hb, RW, 32'ha, 32'hb);
      tick(1'b0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("mid_rst_pc",    ex_pc, 32'd0);
      chk("mid_rst_ctrl",  {16'd0, ex_ctrl}, 32'd0);
      chk("mid_rst_op1",   ex_op1, 32'd0);
      chk("mid_rst_rd",    {27'd0, ex_rd}, 32'd0);
      sb.delete();
      id_set(1'b1, 32'h204, 5'd4, 5'd5, 5'd6, 32'hc, 32'hd, RW, 32'hc, 32'hd);
      @(negedge clk);
      #1 rst = 1'b1;
      sb.push_back(pend);
      @(posedge clk);
      #1;
      id_set(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0);
      tick(1'b0);
      tick(1'b0);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
